rand_range_capture: RTL and testbench
=====================================

Name: rand_range_capture

Overview:
Sits directly downstream of the free-running press counter in the random number generator. It watches the same `enable` (button-held) signal that drives that counter. On the falling edge of `enable` it snapshots `counter_value`, reduces it to the range [RANGE_MIN, RANGE_MAX] with a serial modulo, and presents the result on a valid/ready output to the display/consumer stage.

Parameters:
- CNT_W, 32: width of `counter_value`.
- OUT_W, 8: width of `rand_value`.
- RANGE_MIN, 1: smallest result value.
- RANGE_MAX, 100: largest result value.
- Derived SPAN = RANGE_MAX - RANGE_MIN + 1 (localparam).
- Elaboration checks: RANGE_MIN <= RANGE_MAX; RANGE_MAX < 2**OUT_W; SPAN <= 2**CNT_W.

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-high.
- enable, in, 1: button-held level, same net as the counter's enable.
- counter_value, in, CNT_W: running count from the press counter.
- rand_value, out, OUT_W: reduced random result; stable while `rand_valid` is high.
- rand_valid, out, 1: result available.
- rand_ready, in, 1: consumer accepts the result.
- busy, out, 1: high in REDUCE and HOLD.
- dropped, out, 1: one-cycle pulse when a capture is ignored.

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - state=IDLE; enable_d=0; rand_value=0; rand_valid=0; busy=0; dropped=0; shift/remainder regs=0.
  - enable_d=0 means an `enable` held high through reset release yields no false edge; a falling edge needs one sampled high first.
- enable_d <= enable every cycle in all states.
- fall = enable_d & ~enable.
- States:
  - IDLE: on fall, latch counter_value into shreg, clear rem, bit index = CNT_W-1, go to REDUCE. `rand_ready` is ignored in IDLE.
  - REDUCE: one bit per clock, MSB first.
    - t = {rem, shreg[MSB]}; rem <= (t >= SPAN) ? t - SPAN : t; shreg <<= 1.
    - rem width is CNT_W+1 bits, so no overflow.
    - After the CNT_W-th bit: rand_value <= rem + RANGE_MIN (truncated to OUT_W; fits by the checks); rand_valid <= 1; go to HOLD.
  - HOLD: hold rand_value and rand_valid. When rand_valid & rand_ready at a clock edge: rand_valid <= 0, go to IDLE.
- Latency: capture edge E0; rand_valid rises at edge E0+CNT_W (32 cycles at default). It is registered, with no combinational path from `rand_ready` to outputs.
- Fall while busy (REDUCE or HOLD): capture ignored, dropped=1 for exactly one cycle. No queueing.
- Accept and fall on the same edge in HOLD:
  - Transfer completes and the fall counts as dropped.
  - The next capture needs a later fall.
- counter_value=0 gives rand_value=RANGE_MIN. Full-scale (all ones) is legal.
- SPAN=1 gives rand_value=RANGE_MIN always, with the same latency.

Decomposition:
- Package rng_pkg:
  - state enum {IDLE, REDUCE, HOLD};
  - CNT_W default constant shared with the counter;
  - a width helper function (clog2-based) for the bit index.
- One sub-module, mod_reducer:
  - the serial shift-subtract remainder datapath;
  - start/done handshake;
  - parameters CNT_W and SPAN.
- The FSM, edge detect and output handshake stay in rand_range_capture.

Test Plan:
1. Defaults (1..100); enable high, then low with counter_value=250 at the falling sample -> rand_valid rises 32 cycles later, rand_value=51; rand_ready=1 -> valid drops the next cycle.
2. Defaults; counter_value=0xFFFFFFFF at the fall -> rand_value=96 (4294967295 mod 100 = 95, +1).
3. RANGE_MIN=1, RANGE_MAX=6; counts 17 and 12 captured on successive presses -> 6, then 1; busy high exactly from E0+1 until acceptance.
4. Backpressure: rand_ready=0 for 10 cycles after valid -> rand_value stable, valid held. A second enable fall during HOLD -> dropped pulses for 1 cycle and no new result after acceptance.
5. Reset asserted mid-REDUCE (cycle 10) -> outputs 0 immediately. Release with `enable` already high produces no capture. The next real fall with counter_value=250 -> 51 after 32 cycles.
6. Accept and fall on the same edge -> one result delivered, dropped=1, state IDLE, no second result.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number capture path.
// Holds the FSM state type, the press counter width and a bit-index width helper.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    HOLD
  } state_t;

  localparam int CNT_W_DEFAULT = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_reducer.sv
// Serial shift-subtract remainder: din mod SPAN, one bit per clock, MSB first; CNT_W clocks after start.
// done is asserted during the last bit and result is that bit's remainder; start is only honoured when idle.
module mod_reducer
  import rng_pkg::*;
#(
  parameter int              CNT_W = CNT_W_DEFAULT,
  parameter longint unsigned SPAN  = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] din,
  output logic             done,
  output logic [CNT_W+1:0] result
);

  localparam int IW = idx_w(CNT_W);
  localparam logic [CNT_W+1:0] SPAN_W = (CNT_W+2)'(SPAN);

  logic [CNT_W-1:0] shreg;
  logic [CNT_W:0]   rem;
  logic [IW-1:0]    idx;
  logic             active;
  logic [CNT_W+1:0] t;
  logic [CNT_W+1:0] rem_next;

  always_comb begin
    t        = {rem, shreg[CNT_W-1]};
    rem_next = (t >= SPAN_W) ? (t - SPAN_W) : t;
  end

  assign done   = active && (idx == '0);
  assign result = rem_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      rem    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (start && !active) begin
      shreg  <= din;
      rem    <= '0;
      idx    <= IW'(CNT_W - 1);
      active <= 1'b1;
    end else if (active) begin
      // rem stays below SPAN, so the top bit of rem_next is always zero here
      rem   <= rem_next[CNT_W:0];
      shreg <= shreg << 1;
      if (idx == '0) begin
        active <= 1'b0;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: rtl/rand_range_capture.sv
// Snapshots counter_value on the falling edge of enable and returns it reduced into [RANGE_MIN, RANGE_MAX].
// rand_valid rises CNT_W clocks after the capture edge and holds until rand_ready; falls while busy are dropped.
module rand_range_capture
  import rng_pkg::*;
#(
  parameter int          CNT_W     = CNT_W_DEFAULT,
  parameter int          OUT_W     = 8,
  parameter int unsigned RANGE_MIN = 1,
  parameter int unsigned RANGE_MAX = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] counter_value,
  output logic [OUT_W-1:0] rand_value,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic             busy,
  output logic             dropped
);

  localparam longint unsigned SPAN = longint'(RANGE_MAX) - longint'(RANGE_MIN) + 1;

  if (RANGE_MIN > RANGE_MAX) begin : g_bad_range
    $error("rand_range_capture: RANGE_MIN must not exceed RANGE_MAX");
  end
  if (OUT_W < 32 && longint'(RANGE_MAX) >= (longint'(1) << OUT_W)) begin : g_bad_out_w
    $error("rand_range_capture: RANGE_MAX does not fit in OUT_W bits");
  end
  if (CNT_W < 62 && SPAN > (longint'(1) << CNT_W)) begin : g_bad_span
    $error("rand_range_capture: SPAN exceeds 2**CNT_W");
  end

  state_t           state, state_nxt;
  logic             enable_d;
  logic             fall;
  logic             red_start;
  logic             red_done;
  logic [CNT_W+1:0] red_result;
  logic [OUT_W-1:0] value_nxt;
  logic             valid_nxt;
  logic             dropped_nxt;

  mod_reducer #(
    .CNT_W (CNT_W),
    .SPAN  (SPAN)
  ) u_mod_reducer (
    .clk    (clk),
    .reset  (reset),
    .start  (red_start),
    .din    (counter_value),
    .done   (red_done),
    .result (red_result)
  );

  assign fall = enable_d & ~enable;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    value_nxt   = rand_value;
    valid_nxt   = rand_valid;
    dropped_nxt = 1'b0;
    red_start   = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          red_start = 1'b1;
          state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        dropped_nxt = fall;
        if (red_done) begin
          value_nxt = OUT_W'(red_result + (CNT_W+2)'(RANGE_MIN));
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A fall coinciding with acceptance is still a drop: no queueing
        dropped_nxt = fall;
        if (rand_valid && rand_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      enable_d   <= 1'b0;
      rand_value <= '0;
      rand_valid <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      enable_d   <= enable;
      rand_value <= value_nxt;
      rand_valid <= valid_nxt;
      dropped    <= dropped_nxt;
    end
  end

endmodule

// File: tb/tb_rand_range_capture.sv
// Drives two instances (ranges 1..100 and 1..6) with shared stimulus and checks them against a modulo model.
module tb_rand_range_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rand_ready;
  logic [31:0] counter_value;
  logic [7:0]  rv_a, rv_b;
  logic        vld_a, vld_b, busy_a, busy_b, drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rand_range_capture dut_a (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .counter_value (counter_value),
    .rand_value    (rv_a),
    .rand_valid    (vld_a),
    .rand_ready    (rand_ready),
    .busy          (busy_a),
    .dropped       (drop_a)
  );

  rand_range_capture #(
    .RANGE_MIN (1),
    .RANGE_MAX (6)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .counter_value (counter_value),
    .rand_value    (rv_b),
    .rand_valid    (vld_b),
    .rand_ready    (rand_ready),
    .busy          (busy_b),
    .dropped       (drop_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input longint unsigned cnt, input longint lo, input longint hi);
    return longint'(cnt % longint'(hi - lo + 1)) + lo;
  endfunction

  // One press: capture cnt, hold off acceptance for `hold` cycles, optionally
  // fall again during HOLD, or fall on the same edge as acceptance.
  task automatic capture(input logic [31:0] cnt, input int hold, input bit extra_fall, input bit same_edge);
    int     n;
    int     ndrop;
    int     late_vld;
    bit     busy_ok;
    bit     stable;
    longint exp_a, exp_b;
    exp_a = model(cnt, 1, 100);
    exp_b = model(cnt, 1, 6);

    @(posedge clk); #1; enable = 1'b1; counter_value = $urandom;
    @(posedge clk); #1; enable = 1'b0; counter_value = cnt;
    @(negedge clk); check("busy_before_fall", busy_a, 0);
    @(posedge clk); #1; counter_value = $urandom;
    @(negedge clk); check("busy_after_fall", {busy_a, busy_b}, 2'b11);

    n = 0;
    busy_ok = 1'b1;
    while (!vld_a && n < 100) begin
      @(negedge clk);
      n++;
      if (!busy_a || !busy_b) busy_ok = 1'b0;
    end
    check("latency", n, 32);
    check("busy_during_reduce", busy_ok, 1);
    check("valid_b", vld_b, 1);
    check("value_a", rv_a, exp_a);
    check("value_b", rv_b, exp_b);

    stable = 1'b1;
    ndrop = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (extra_fall && i == 0) enable = 1'b1;
      else if (extra_fall && i == 1) enable = 1'b0;
      @(negedge clk);
      if (rv_a !== exp_a[7:0] || rv_b !== exp_b[7:0] || !vld_a || !vld_b || !busy_a) stable = 1'b0;
      ndrop += int'(drop_a) + int'(drop_b);
    end
    if (hold > 0) begin
      check("hold_stable", stable, 1);
      check("hold_drops", ndrop, extra_fall ? 2 : 0);
    end

    if (same_edge) begin
      @(posedge clk); #1; enable = 1'b1;
      @(posedge clk); #1; enable = 1'b0; rand_ready = 1'b1;
    end else begin
      @(posedge clk); #1; rand_ready = 1'b1;
    end
    @(posedge clk); #1; rand_ready = 1'b0;
    @(negedge clk);
    check("accept_valid", {vld_a, vld_b}, 2'b00);
    check("accept_busy", {busy_a, busy_b}, 2'b00);
    check("accept_dropped", {drop_a, drop_b}, same_edge ? 2'b11 : 2'b00);

    if (extra_fall || same_edge) begin
      late_vld = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        late_vld += int'(vld_a) + int'(busy_a) + int'(drop_a);
      end
      check("no_second_result", late_vld, 0);
    end
  endtask

  initial begin
    int idle_busy;
    reset = 1'b1;
    enable = 1'b0;
    rand_ready = 1'b0;
    counter_value = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rv_a, vld_a, busy_a, drop_a, rv_b, vld_b, busy_b, drop_b}, 0);
    @(posedge clk); #1; reset = 1'b0;
    idle_busy = 0;
    repeat (5) begin
      @(negedge clk);
      idle_busy += int'(busy_a) + int'(vld_a) + int'(drop_a);
    end
    check("idle_after_reset", idle_busy, 0);

    capture(32'd250, 2, 1'b0, 1'b0);
    capture(32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    capture(32'd17, 0, 1'b0, 1'b0);
    capture(32'd12, 0, 1'b0, 1'b0);
    capture($urandom, 10, 1'b1, 1'b0);

    // Reset in the middle of a reduction, with enable held high across release
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; enable = 1'b0; counter_value = $urandom;
    repeat (11) @(posedge clk);
    #2;
    check("busy_before_reset", busy_a, 1);
    enable = 1'b1;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {rv_a, vld_a, busy_a, drop_a, rv_b, vld_b, busy_b, drop_b}, 0);
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    idle_busy = 0;
    repeat (6) begin
      @(negedge clk);
      idle_busy += int'(busy_a) + int'(vld_a) + int'(drop_a);
    end
    check("no_capture_on_release", idle_busy, 0);
    capture(32'd250, 0, 1'b0, 1'b0);

    capture($urandom, 1, 1'b0, 1'b1);
    capture(32'd0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      bit xf;
      int h;
      xf = 1'($urandom_range(0, 1));
      h  = xf ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 5));
      capture($urandom, h, xf, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
